div0_result_writer: RTL and testbench
=====================================

Name: div0_result_writer

Overview:
- Divide-by-zero responder for the division programs.
- Samples the divisor at the program's zero-check point. On a zero divisor it takes the data-memory write port through a request/grant handshake and writes a saturated result (all 0xFF bytes) to the program's result area.
- It then flags the exception, latches the cause and halts the core until the next program load.

Parameters:
- ADDR_W, 8, data-memory address width.
- P1_BASE, 8'h04, first result address for program 1 (ProgState 01).
- P1_LEN, 3, result bytes written for program 1.
- P2_BASE, 8'h08, first result address for program 2 (ProgState 10).
- P2_LEN, 2, result bytes written for program 2.
- SAT_VAL, 8'hFF, byte value written on exception.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ProgState  in  2  current program: 00 idle/load, 01 prog1 (16-bit divisor), 10 prog2 (8-bit divisor), 11 prog3.
- DivCheck  in  1  one-cycle pulse when the PC reaches the program's zero-check point.
- DivisorMsb  in  8  latched divisor high byte (prog2 divisor).
- DivisorLsb  in  8  latched divisor low byte (prog1 only).
- MemGnt  in  1  memory arbiter grant for this cycle.
- MemReq  out  1  write-port request.
- MemAddr  out  ADDR_W  write address.
- MemData  out  8  write data.
- MemWen  out  1  write strobe = MemReq & MemGnt.
- ExcFlag  out  1  exception pending.
- ExcCause  out  2  ProgState captured at the exception.
- Halt  out  1  stall request to the fetch stage.
- ExcCount  out  8  saturating exception counter.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE; MemReq=0; MemAddr=0; MemData=0; ExcFlag=0; ExcCause=00; Halt=0; ExcCount=0; byte counter=0.
- States are IDLE, WRITE and HALT. All outputs are registered except MemWen.
- Zero test:
  - ProgState 01: {DivisorMsb,DivisorLsb}==16'h0000.
  - ProgState 10: DivisorMsb==8'h00.
  - ProgState 00 and 11: DivCheck is ignored.
- IDLE -> WRITE, on DivCheck with the zero test true:
  - Next cycle: MemReq=1; MemAddr=base; MemData=SAT_VAL; ExcFlag=1; ExcCause=ProgState; Halt=1.
  - ExcCount increments, saturating at 8'hFF.
  - Byte counter loads the program's LEN.
  - Base and LEN are latched at entry; later ProgState changes other than to 00 do not alter them.
- DivCheck with the zero test false: no output change.
- WRITE:
  - MemAddr and MemData are held stable while MemReq=1 && MemGnt=0; wait cycles are unbounded.
  - Each cycle with MemGnt=1 writes one byte (MemWen=1), increments MemAddr and decrements the counter.
  - When the last byte is granted, the next cycle has MemReq=0 and state HALT.
  - Minimum latency is DivCheck to first MemWen = 1 cycle (grant held high); N bytes take N granted cycles.
- HALT: ExcFlag=1 and Halt=1 are held until ProgState==00, then the next cycle returns to IDLE with ExcFlag=0, Halt=0 and ExcCause=00.
- MemAddr wraps modulo 2^ADDR_W; no error is raised.
- ProgState==00 during WRITE aborts the operation:
  - Next cycle: IDLE, MemReq=0, Halt=0, ExcFlag=0.
  - Bytes already granted stay written.
  - ExcCount keeps its incremented value.
- DivCheck during WRITE or HALT is ignored; the count does not increment.
- DivCheck and ProgState->00 in the same cycle in IDLE: ProgState is already 00, so no entry.
- MemGnt while MemReq=0 has no effect; MemWen stays 0.
- ExcCount clears only on reset.

Decomposition:
- Shared package (div_pkg), holding:
  - the ProgState encodings (PS_IDLE, PS_P1, PS_P2, PS_P3);
  - the state enum (IDLE, WRITE, HALT);
  - the P1/P2 base, length and SAT_VAL constants as defaults.
- No sub-module: the FSM, address counter and byte counter stay in one module.

Test Plan:
1. Prog1 zero divisor:
   - Stimulus: ProgState=01, Msb=Lsb=00, DivCheck pulse, MemGnt=1.
   - Response: writes FF to 04, 05, 06 on 3 consecutive cycles; ExcCause=01; Halt=1 until ProgState=00, then all clear; ExcCount=1.
2. Nonzero divisors:
   - Stimulus: ProgState=01 with Lsb=01, then ProgState=10 with Msb=05, DivCheck each.
   - Response: MemReq never asserts; ExcFlag=0; ExcCount=0.
3. Prog2 zero divisor with stalled grant:
   - Stimulus: ProgState=10, Msb=00, Lsb=7A, DivCheck; MemGnt low 4 cycles, then high.
   - Response: MemAddr=08 and MemData=FF stable while stalled; writes land at 08 and 09 only; ExcCause=10.
4. Abort mid-write:
   - Stimulus: prog1 exception, grant first byte only, then ProgState=00.
   - Response: only address 04 written; next cycle MemReq=0, Halt=0, ExcFlag=0; ExcCount=1.
5. Ignored checks:
   - Stimulus: DivCheck during HALT; DivCheck with ProgState=11 and zero divisor.
   - Response: no new writes; ExcCount unchanged.
6. Async reset and counter saturation:
   - Stimulus: assert RST_N low between clock edges mid-WRITE.
   - Response: all outputs 0 immediately.
   - Stimulus: 256 complete exception cycles.
   - Response: ExcCount holds FF.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings and default constants for the divide-by-zero result writer.
package div_pkg;

   // Program selector encodings on ProgState
   localparam logic [1:0] PS_IDLE = 2'b00;
   localparam logic [1:0] PS_P1   = 2'b01;
   localparam logic [1:0] PS_P2   = 2'b10;
   localparam logic [1:0] PS_P3   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      HALT  = 2'b10
   } state_t;

   // Default result-area layout and saturation byte
   localparam int unsigned ADDR_W_D  = 8;
   localparam logic [7:0]  P1_BASE_D = 8'h04;
   localparam int unsigned P1_LEN_D  = 3;
   localparam logic [7:0]  P2_BASE_D = 8'h08;
   localparam int unsigned P2_LEN_D  = 2;
   localparam logic [7:0]  SAT_VAL_D = 8'hFF;

   // Program 1 divides by a 16-bit value, program 2 by the high byte only;
   // the other program states never raise a divide-by-zero.
   function automatic logic div_is_zero(input logic [1:0] ps,
                                        input logic [7:0] msb,
                                        input logic [7:0] lsb);
      logic z;
      z = 1'b0;
      if (ps == PS_P1)
         z = ({msb, lsb} == 16'h0000);
      else if (ps == PS_P2)
         z = (msb == 8'h00);
      return z;
   endfunction

endpackage

// File: rtl/div0_result_writer.sv
// Divide-by-zero responder: on a zero divisor at the program's check point,
// writes saturated bytes into the result area through the shared write port,
// flags the exception and holds the core halted until the next program load.
//
// state | meaning
// IDLE  | waiting for a zero-check pulse with a zero divisor
// WRITE | requesting the write port, one byte per granted cycle
// HALT  | result written; exception flagged, core stalled until ProgState==00
module div0_result_writer
   import div_pkg::*;
#(
   parameter int unsigned        ADDR_W  = ADDR_W_D,
   parameter logic [ADDR_W-1:0]  P1_BASE = P1_BASE_D,
   parameter int unsigned        P1_LEN  = P1_LEN_D,
   parameter logic [ADDR_W-1:0]  P2_BASE = P2_BASE_D,
   parameter int unsigned        P2_LEN  = P2_LEN_D,
   parameter logic [7:0]         SAT_VAL = SAT_VAL_D
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [1:0]        ProgState,
   input  logic              DivCheck,
   input  logic [7:0]        DivisorMsb,
   input  logic [7:0]        DivisorLsb,
   input  logic              MemGnt,
   output logic              MemReq,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [7:0]        MemData,
   output logic              MemWen,
   output logic              ExcFlag,
   output logic [1:0]        ExcCause,
   output logic              Halt,
   output logic [7:0]        ExcCount
);

   state_t     state;
   logic [7:0] byte_cnt;
   logic       zero_hit;

   // Zero test only counts when the pulse arrives for a dividing program
   always_comb begin
      zero_hit = DivCheck & div_is_zero(ProgState, DivisorMsb, DivisorLsb);
   end

   // The write strobe is the only unregistered output so the grant lands same cycle
   assign MemWen = MemReq & MemGnt;

   // Sequencer, address/byte counters and exception bookkeeping
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         MemReq   <= 1'b0;
         MemAddr  <= '0;
         MemData  <= 8'h00;
         ExcFlag  <= 1'b0;
         ExcCause <= PS_IDLE;
         Halt     <= 1'b0;
         ExcCount <= 8'h00;
         byte_cnt <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (zero_hit) begin
                  state    <= WRITE;
                  MemReq   <= 1'b1;
                  MemData  <= SAT_VAL;
                  ExcFlag  <= 1'b1;
                  ExcCause <= ProgState;
                  Halt     <= 1'b1;
                  if (ExcCount != 8'hFF)
                     ExcCount <= ExcCount + 8'd1;
                  // Base/length are captured here; MemAddr and byte_cnt carry them
                  if (ProgState == PS_P1) begin
                     MemAddr  <= P1_BASE;
                     byte_cnt <= 8'(P1_LEN);
                  end else begin
                     MemAddr  <= P2_BASE;
                     byte_cnt <= 8'(P2_LEN);
                  end
               end
            end
            WRITE: begin
               if (ProgState == PS_IDLE) begin
                  // Program reload aborts; bytes already granted stay in memory
                  state    <= IDLE;
                  MemReq   <= 1'b0;
                  ExcFlag  <= 1'b0;
                  ExcCause <= PS_IDLE;
                  Halt     <= 1'b0;
                  byte_cnt <= 8'h00;
               end else if (MemGnt) begin
                  MemAddr  <= MemAddr + 1'b1;
                  byte_cnt <= byte_cnt - 8'd1;
                  if (byte_cnt == 8'd1) begin
                     state  <= HALT;
                     MemReq <= 1'b0;
                  end
               end
            end
            HALT: begin
               if (ProgState == PS_IDLE) begin
                  state    <= IDLE;
                  ExcFlag  <= 1'b0;
                  ExcCause <= PS_IDLE;
                  Halt     <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               MemReq <= 1'b0;
               Halt   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div0_result_writer.sv
// Self-checking bench for div0_result_writer: a table of single-exception
// scenarios, hand sequences for stalls/abort/reset/saturation, and randomized
// episodes checked against a transaction-level model of the result writes.
module tb_div0_result_writer;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [1:0] ProgState;
   logic       DivCheck;
   logic [7:0] DivisorMsb;
   logic [7:0] DivisorLsb;
   logic       MemGnt;
   logic       MemReq;
   logic [7:0] MemAddr;
   logic [7:0] MemData;
   logic       MemWen;
   logic       ExcFlag;
   logic [1:0] ExcCause;
   logic       Halt;
   logic [7:0] ExcCount;

   int checks = 0;
   int passed = 0;
   int exp_cnt = 0;
   logic [15:0] wlog[$];

   div0_result_writer dut (
      .CLK(CLK), .RST_N(RST_N), .ProgState(ProgState), .DivCheck(DivCheck),
      .DivisorMsb(DivisorMsb), .DivisorLsb(DivisorLsb), .MemGnt(MemGnt),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemWen(MemWen),
      .ExcFlag(ExcFlag), .ExcCause(ExcCause), .Halt(Halt), .ExcCount(ExcCount)
   );

   always #5 CLK = ~CLK;

   // Record every byte that actually hits memory
   always @(posedge CLK) begin
      if (MemWen) wlog.push_back({MemAddr, MemData});
   end

   typedef struct {
      logic [1:0] ps;
      logic [7:0] msb;
      logic [7:0] lsb;
      bit         exc;
      logic [7:0] base;
      int         len;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] sat_cnt();
      return (exp_cnt > 255) ? 8'hFF : 8'(exp_cnt);
   endfunction

   task automatic check_log(input string name, input logic [7:0] base, input int len);
      chk({name, "_nwr"}, wlog.size(), len);
      for (int i = 0; i < len && i < wlog.size(); i++) begin
         logic [7:0] a;
         a = base + 8'(i);
         chk({name, "_wr"}, wlog[i], {a, 8'hFF});
      end
   endtask

   // Drain the write phase with a given grant policy; returns granted cycles
   task automatic drain(input string name, input bit rnd, output int gcyc);
      int n;
      n = 0;
      gcyc = 0;
      while (MemReq && n < 300) begin
         MemGnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (MemGnt) gcyc++;
         step();
         n++;
      end
      MemGnt = 1'b0;
      chk({name, "_timeout"}, MemReq, 0);
   endtask

   task automatic release_halt(input string name);
      ProgState = 2'b00;
      step();
      chk({name, "_rel_halt"}, Halt, 0);
      chk({name, "_rel_flag"}, ExcFlag, 0);
      chk({name, "_rel_cause"}, ExcCause, 0);
   endtask

   task automatic pulse(input logic [1:0] ps, input logic [7:0] msb, input logic [7:0] lsb);
      ProgState = ps; DivisorMsb = msb; DivisorLsb = lsb;
      DivCheck = 1'b1;
      step();
      DivCheck = 1'b0;
   endtask

   vec_t vecs[8];

   initial begin
      int g;
      RST_N = 1'b0; ProgState = 2'b00; DivCheck = 1'b0;
      DivisorMsb = 8'h00; DivisorLsb = 8'h00; MemGnt = 1'b0;
      repeat (2) step();
      chk("rst_req", MemReq, 0);
      chk("rst_addr", MemAddr, 0);
      chk("rst_data", MemData, 0);
      chk("rst_flag", ExcFlag, 0);
      chk("rst_halt", Halt, 0);
      chk("rst_cnt", ExcCount, 0);
      @(negedge CLK); RST_N = 1'b1;
      step();

      vecs[0] = '{2'b01, 8'h00, 8'h00, 1'b1, 8'h04, 3};
      vecs[1] = '{2'b01, 8'h00, 8'h01, 1'b0, 8'h00, 0};
      vecs[2] = '{2'b10, 8'h05, 8'h00, 1'b0, 8'h00, 0};
      vecs[3] = '{2'b01, 8'h01, 8'h00, 1'b0, 8'h00, 0};
      vecs[4] = '{2'b10, 8'h00, 8'h7A, 1'b1, 8'h08, 2};
      vecs[5] = '{2'b11, 8'h00, 8'h00, 1'b0, 8'h00, 0};
      vecs[6] = '{2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 0};
      vecs[7] = '{2'b10, 8'h00, 8'h00, 1'b1, 8'h08, 2};

      for (int i = 0; i < 8; i++) begin
         wlog.delete();
         MemGnt = 1'b1;
         pulse(vecs[i].ps, vecs[i].msb, vecs[i].lsb);
         if (vecs[i].exc) exp_cnt++;
         chk("tbl_req", MemReq, vecs[i].exc);
         chk("tbl_flag", ExcFlag, vecs[i].exc);
         chk("tbl_halt", Halt, vecs[i].exc);
         chk("tbl_cause", ExcCause, vecs[i].exc ? vecs[i].ps : 2'b00);
         if (vecs[i].exc) chk("tbl_addr0", MemAddr, vecs[i].base);
         drain("tbl", 1'b0, g);
         chk("tbl_gcyc", g, vecs[i].len);
         check_log("tbl", vecs[i].base, vecs[i].len);
         chk("tbl_cnt", ExcCount, sat_cnt());
         if (vecs[i].exc) begin
            step();
            chk("tbl_halt_hold", Halt, 1);
            chk("tbl_flag_hold", ExcFlag, 1);
            release_halt("tbl");
         end else begin
            ProgState = 2'b00;
            step();
         end
      end

      // Stalled grant on program 2: address/data must hold while waiting
      wlog.delete();
      MemGnt = 1'b0;
      pulse(2'b10, 8'h00, 8'h7A);
      exp_cnt++;
      for (int i = 0; i < 4; i++) begin
         chk("stall_addr", MemAddr, 8'h08);
         chk("stall_data", MemData, 8'hFF);
         chk("stall_wen", MemWen, 0);
         step();
      end
      chk("stall_cause", ExcCause, 2'b10);
      drain("stall", 1'b0, g);
      check_log("stall", 8'h08, 2);
      release_halt("stall");

      // Abort after first granted byte
      wlog.delete();
      MemGnt = 1'b0;
      pulse(2'b01, 8'h00, 8'h00);
      exp_cnt++;
      MemGnt = 1'b1;
      step();
      MemGnt = 1'b0;
      ProgState = 2'b00;
      step();
      chk("abort_req", MemReq, 0);
      chk("abort_halt", Halt, 0);
      chk("abort_flag", ExcFlag, 0);
      chk("abort_cnt", ExcCount, sat_cnt());
      repeat (2) step();
      check_log("abort", 8'h04, 1);

      // DivCheck in HALT and prog3 zero divisor are ignored
      wlog.delete();
      MemGnt = 1'b1;
      pulse(2'b10, 8'h00, 8'h00);
      exp_cnt++;
      drain("ign", 1'b0, g);
      wlog.delete();
      pulse(2'b10, 8'h00, 8'h00);
      step();
      chk("ign_halt_cnt", ExcCount, sat_cnt());
      chk("ign_halt_wr", wlog.size(), 0);
      release_halt("ign");
      pulse(2'b11, 8'h00, 8'h00);
      step();
      chk("ign_p3_req", MemReq, 0);
      chk("ign_p3_cnt", ExcCount, sat_cnt());
      chk("ign_p3_wr", wlog.size(), 0);
      ProgState = 2'b00;
      step();

      // Randomized episodes against the transaction model
      for (int e = 0; e < 40; e++) begin
         logic [1:0] ps;
         logic [7:0] msb, lsb;
         bit z;
         logic [7:0] base;
         int len;
         ps  = 2'($urandom_range(0, 3));
         msb = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         lsb = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         z = (ps == 2'b01 && msb == 0 && lsb == 0) || (ps == 2'b10 && msb == 0);
         base = (ps == 2'b01) ? 8'h04 : 8'h08;
         len  = !z ? 0 : (ps == 2'b01) ? 3 : 2;
         wlog.delete();
         MemGnt = 1'($urandom_range(0, 1));
         pulse(ps, msb, lsb);
         if (z) exp_cnt++;
         chk("rnd_flag", ExcFlag, z);
         chk("rnd_cause", ExcCause, z ? ps : 2'b00);
         drain("rnd", 1'b1, g);
         MemGnt = 1'($urandom_range(0, 1));
         step();
         check_log("rnd", base, len);
         chk("rnd_halt", Halt, z);
         chk("rnd_cnt", ExcCount, sat_cnt());
         release_halt("rnd");
      end

      // Asynchronous reset in the middle of a stalled write
      MemGnt = 1'b0;
      pulse(2'b01, 8'h00, 8'h00);
      step();
      #3;
      RST_N = 1'b0;
      #1;
      chk("arst_req", MemReq, 0);
      chk("arst_addr", MemAddr, 0);
      chk("arst_data", MemData, 0);
      chk("arst_flag", ExcFlag, 0);
      chk("arst_cause", ExcCause, 0);
      chk("arst_halt", Halt, 0);
      chk("arst_cnt", ExcCount, 0);
      exp_cnt = 0;
      ProgState = 2'b00;
      @(negedge CLK); RST_N = 1'b1;
      step();

      // Counter saturation across 256 complete exceptions
      for (int k = 1; k <= 256; k++) begin
         MemGnt = 1'b1;
         pulse(2'b10, 8'h00, 8'h11);
         exp_cnt++;
         drain("sat", 1'b0, g);
         ProgState = 2'b00;
         step();
         if (k == 254 || k >= 255) chk("sat_cnt", ExcCount, sat_cnt());
      end
      chk("sat_final", ExcCount, 8'hFF);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
